// File: rtl/ws2812_frame_feeder.sv
// Frame buffer and pixel feeder for the ws2812 serial driver: scales each pixel
// by a global brightness, reorders RGB to GRB and hands words over on request.

module ws2812_chan_scale (
  input  logic [7:0] c,
  input  logic [7:0] b,
  output logic [7:0] y
);
  logic [8:0]  b1;
  logic [15:0] prod;

  // b+1 makes 255 an exact pass-through and 0 a full blank
  assign b1   = {1'b0, b} + 9'd1;
  assign prod = {8'd0, c} * {7'd0, b1};
  assign y    = prod[15:8];
endmodule

module ws2812_frame_feeder #(
  parameter  int NUM_LEDS  = 8,
  localparam int ADDR_BITS = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [23:0]          wr_rgb,
  output logic                 wr_ready,
  input  logic [7:0]           brightness,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  input  logic                 new_data_req,
  output logic                 send_n,
  output logic [23:0]          rgb_data
);
  localparam int CNT_BITS = $clog2(NUM_LEDS + 1);
  localparam int STAGES   = 2;

  typedef enum logic [1:0] {IDLE, PREFETCH, ARM, STREAM} state_t;
  state_t state, state_nx;

  logic [23:0]          mem [NUM_LEDS];
  logic [23:0]          rd_data;
  logic [7:0]           brightness_l;
  logic [1:0]           rd_idx;
  logic [CNT_BITS-1:0]  sent, sent_inc;
  logic [STAGES-1:0]    vld_pipe;
  logic                 dst_q;
  logic [23:0]          next_word;
  logic                 next_vld;
  logic                 req_q, req_evt;
  logic                 fetch_go, fetch_out, take, done;
  logic [ADDR_BITS-1:0] fetch_addr;
  logic [2:0][7:0]      chan_in, chan_out;
  logic [23:0]          scaled;

  assign busy     = (state != IDLE);
  assign wr_ready = ~busy;
  assign req_evt  = new_data_req & ~req_q;
  assign sent_inc = sent + 1'b1;

  assign chan_in = rd_data;
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    ws2812_chan_scale u_scale (.c(chan_in[ch]), .b(brightness_l), .y(chan_out[ch]));
  end
  assign scaled = {chan_out[1], chan_out[2], chan_out[0]};

  // Pixel RAM, not reset; a write and start in the same cycle lands before the first read
  always_ff @(posedge clk) begin
    if (wr_en && wr_ready && (32'(wr_addr) < NUM_LEDS)) mem[wr_addr] <= wr_rgb;
    if (fetch_go) rd_data <= mem[fetch_addr];
  end

  always_comb begin
    state_nx   = state;
    fetch_go   = 1'b0;
    fetch_out  = 1'b0;
    fetch_addr = '0;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start && !frame_done) state_nx = PREFETCH;
      PREFETCH: begin
        if (rd_idx == 2'd0) begin
          fetch_go  = 1'b1;
          fetch_out = 1'b1;
        end else if (rd_idx == 2'd1 && NUM_LEDS > 1) begin
          fetch_go   = 1'b1;
          fetch_addr = ADDR_BITS'(1);
        end else if (vld_pipe == '0) begin
          state_nx = ARM;
        end
      end
      ARM: if (req_evt) begin
        if (NUM_LEDS == 1) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = STREAM;
        end
      end
      STREAM: if (req_evt && next_vld) begin
        // a request arriving before the prefetch lands is dropped; rgb_data holds
        take = 1'b1;
        if (32'(sent_inc) < NUM_LEDS) begin
          fetch_go   = 1'b1;
          fetch_addr = sent_inc[ADDR_BITS-1:0];
        end else begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      brightness_l <= '0;
      rd_idx       <= '0;
      sent         <= '0;
      vld_pipe     <= '0;
      dst_q        <= 1'b0;
      next_word    <= '0;
      next_vld     <= 1'b0;
      rgb_data     <= '0;
      send_n       <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      req_q      <= new_data_req;
      frame_done <= done;
      send_n     <= !(state_nx == ARM || state_nx == STREAM);
      vld_pipe   <= {vld_pipe[STAGES-2:0], fetch_go};
      dst_q      <= fetch_out;
      if (state == IDLE && state_nx == PREFETCH) begin
        brightness_l <= brightness;
        rd_idx       <= '0;
        sent         <= '0;
        next_vld     <= 1'b0;
      end
      if (state == PREFETCH && fetch_go) rd_idx <= rd_idx + 2'd1;
      if (state == ARM && req_evt) sent <= CNT_BITS'(1);
      if (take) begin
        rgb_data <= next_word;
        sent     <= sent_inc;
        next_vld <= 1'b0;
      end
      // scale stage: pixel 0 of a frame goes straight out, the rest wait in next_word
      if (vld_pipe[0]) begin
        if (dst_q) rgb_data <= scaled;
        else begin
          next_word <= scaled;
          next_vld  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Scoreboard bench: expected GRB words are queued at frame start and popped on each driver pulse.

module tb_ws2812_frame_feeder;
  localparam int N = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset_n;
  logic        wr_en, wr_ready, start, busy, frame_done, new_data_req, send_n;
  logic [2:0]  wr_addr;
  logic [23:0] wr_rgb, rgb_data;
  logic [7:0]  brightness;
  logic        wr_en1, wr_ready1, start1, busy1, frame_done1, req1, send_n1;
  logic [0:0]  wr_addr1;
  logic [23:0] wr_rgb1, rgb1;

  ws2812_frame_feeder #(.NUM_LEDS(N)) u0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .wr_ready(wr_ready), .brightness(brightness), .start(start), .busy(busy),
    .frame_done(frame_done), .new_data_req(new_data_req), .send_n(send_n), .rgb_data(rgb_data));

  ws2812_frame_feeder #(.NUM_LEDS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_rgb(wr_rgb1),
    .wr_ready(wr_ready1), .brightness(brightness), .start(start1), .busy(busy1),
    .frame_done(frame_done1), .new_data_req(req1), .send_n(send_n1), .rgb_data(rgb1));

  int          total = 0, bad = 0, fd_cnt = 0;
  logic [23:0] model [N];
  logic [23:0] sb [$];
  logic [23:0] last_word;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] grb(input logic [23:0] p, input logic [7:0] b);
    int r, g, bl;
    r  = (int'(p[23:16]) * (int'(b) + 1)) >> 8;
    g  = (int'(p[15:8])  * (int'(b) + 1)) >> 8;
    bl = (int'(p[7:0])   * (int'(b) + 1)) >> 8;
    return {g[7:0], r[7:0], bl[7:0]};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_rgb = d;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] b, input bit do_wr, input logic [2:0] a,
                             input logic [23:0] d);
    if (do_wr) begin
      model[a] = d;
      wr_en = 1'b1; wr_addr = a; wr_rgb = d;
    end
    for (int i = 0; i < N; i++) sb.push_back(grb(model[i], b));
    brightness = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    brightness = ~b;
    chk("busy_after_start", busy, 1);
    chk("wr_ready_busy", wr_ready, 0);
  endtask

  task automatic wait_arm(output bit ok);
    int w = 0;
    while (send_n !== 1'b0 && w < 30) begin @(posedge clk); #1; w++; end
    ok = (send_n === 1'b0);
  endtask

  task automatic pulse();
    #1 new_data_req = 1'b1;
    @(posedge clk); #1 new_data_req = 1'b0;
  endtask

  task automatic run_frame(input bit poke);
    bit ok;
    logic [23:0] e;
    wait_arm(ok);
    chk("arm_reached", ok, 1);
    for (int p = 0; p < N; p++) begin
      repeat (8) @(posedge clk);
      if (poke && p == 3) begin
        // host write and a second start while busy must both be ignored
        #1 wr_en = 1'b1; wr_addr = 3'd3; wr_rgb = 24'hABCDEF; start = 1'b1;
        @(posedge clk); #1 wr_en = 1'b0; start = 1'b0;
      end
      pulse();
      e = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
      last_word = e;
      chk($sformatf("word%0d", p), rgb_data, e);
      if (p < N - 1) chk("send_n_low", send_n, 0);
    end
    chk("send_n_end", send_n, 1);
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_end", busy, 0);
    @(posedge clk); #1;
    chk("frame_done_1cyc", frame_done, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_rgb = '0; brightness = '0;
    start = 1'b0; new_data_req = 1'b0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_rgb1 = '0; start1 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_send_n", send_n, 1);
    chk("rst_rgb", rgb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_ready", wr_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // frame 1: full brightness pass-through
    for (int i = 0; i < N; i++) begin
      model[i] = 24'(32'h110000 * (i + 1)) | 24'h0000FF;
      wr(3'(i), model[i]);
    end
    start_frame(8'd255, 1'b0, 3'd0, 24'd0);
    run_frame(1'b1);

    // driver pulses in IDLE change nothing
    for (int k = 0; k < 3; k++) begin repeat (3) @(posedge clk); pulse(); end
    chk("idle_rgb_hold", rgb_data, last_word);
    chk("idle_busy", busy, 0);
    chk("idle_send_n", send_n, 1);

    // frame 2: half scale, known vector, pixel 3 keeps its old value
    wr(3'd0, 24'hFF8040); model[0] = 24'hFF8040;
    start_frame(8'd127, 1'b0, 3'd0, 24'd0);
    wait_arm(ok);
    chk("b127_word0", rgb_data, 24'h407F20);
    run_frame(1'b0);

    // frame 3: brightness 0 blanks everything
    start_frame(8'd0, 1'b0, 3'd0, 24'd0);
    wait_arm(ok);
    chk("b0_word0", rgb_data, 24'h000000);
    run_frame(1'b0);

    // frame 4: write and start in the same cycle
    start_frame(8'd255, 1'b1, 3'd0, 24'h0080FF);
    run_frame(1'b0);
    chk("frame_done_count", fd_cnt, 4);
    chk("sb_empty", sb.size(), 0);

    // single-pixel instance; address 1 is out of range and dropped
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_rgb1 = 24'h123456;
    @(posedge clk); #1 wr_addr1 = 1'b1; wr_rgb1 = 24'hFFFFFF;
    @(posedge clk); #1 wr_en1 = 1'b0;
    brightness = 8'd255; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    chk("n1_busy", busy1, 1);
    begin
      int w = 0;
      while (send_n1 !== 1'b0 && w < 30) begin @(posedge clk); #1; w++; end
    end
    chk("n1_arm", send_n1, 0);
    chk("n1_word", rgb1, grb(24'h123456, 8'd255));
    repeat (5) @(posedge clk);
    #1 req1 = 1'b1;
    @(posedge clk); #1 req1 = 1'b0;
    chk("n1_send_n", send_n1, 1);
    chk("n1_frame_done", frame_done1, 1);
    chk("n1_busy_end", busy1, 0);
    @(posedge clk); #1;
    chk("n1_frame_done_1cyc", frame_done1, 0);

    // reset in the middle of a frame
    start_frame(8'd200, 1'b0, 3'd0, 24'd0);
    wait_arm(ok);
    repeat (4) @(posedge clk); pulse();
    repeat (4) @(posedge clk); pulse();
    chk("mid_word1", rgb_data, grb(model[1], 8'd200));
    @(posedge clk); #5 reset_n = 1'b0;
    #1;
    chk("arst_send_n", send_n, 1);
    chk("arst_rgb", rgb_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wr_ready", wr_ready, 1);
    sb.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
